// File: rtl/div_ctrl.sv
// Sequencing controller sharing one unsigned multi-cycle divider core between
// div/mod/divu/modu: sign pre-processing, stream handshake, fix-up, flush drain.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [3:0]         req_op,
  input  logic [WIDTH-1:0]   req_src1,
  input  logic [WIDTH-1:0]   req_src2,
  input  logic               out_ready,
  input  logic               flush,
  output logic               div_stall,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_data,
  output logic               core_dividend_tvalid,
  input  logic               core_dividend_tready,
  output logic [WIDTH-1:0]   core_dividend_tdata,
  output logic               core_divisor_tvalid,
  input  logic               core_divisor_tready,
  output logic [WIDTH-1:0]   core_divisor_tdata,
  input  logic               core_dout_tvalid,
  input  logic [2*WIDTH-1:0] core_dout_tdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t           state, state_next;
  logic             s1_q, s2_q, sel_quot_q;
  logic             dvd_sent, dvs_sent, flush_seen;
  logic [WIDTH-1:0] dividend_q, divisor_q, res_q;

  logic             req_signed, req_is_rem, req_is_quot, req_s1, req_s2, req_zero, accept;
  logic             dvd_fire, dvs_fire, dvd_done, dvs_done;
  logic [WIDTH-1:0] q_raw, r_raw, q_fix, r_fix, res_fix, zero_res;

  // op bits: [0]=div, [1]=mod, [2]=divu, [3]=modu
  assign req_signed  = req_op[0] | req_op[1];
  assign req_is_rem  = req_op[1] | req_op[3];
  assign req_is_quot = req_op[0] | req_op[2];
  assign req_s1      = req_src1[WIDTH-1] & req_signed;
  assign req_s2      = req_src2[WIDTH-1] & req_signed;
  assign req_zero    = (req_src2 == '0);
  assign accept      = req_valid & ~flush;
  assign zero_res    = req_is_rem ? req_src1 : '0;

  assign dvd_fire = core_dividend_tvalid & core_dividend_tready;
  assign dvs_fire = core_divisor_tvalid & core_divisor_tready;
  assign dvd_done = dvd_sent | dvd_fire;
  assign dvs_done = dvs_sent | dvs_fire;

  // Magnitudes were divided; restore signs (0x80000000 / -1 wraps to itself)
  assign q_raw   = core_dout_tdata[2*WIDTH-1:WIDTH];
  assign r_raw   = core_dout_tdata[WIDTH-1:0];
  assign q_fix   = (s1_q ^ s2_q) ? (~q_raw + 1'b1) : q_raw;
  assign r_fix   = s1_q ? (~r_raw + 1'b1) : r_raw;
  assign res_fix = sel_quot_q ? q_fix : r_fix;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = req_zero ? DONE : ISSUE;
      ISSUE: if (dvd_done && dvs_done) state_next = (flush_seen || flush) ? DRAIN : WAIT;
      WAIT: begin
        if (core_dout_tvalid) state_next = flush ? IDLE : DONE;
        else if (flush)       state_next = DRAIN;
      end
      DRAIN: if (core_dout_tvalid) state_next = IDLE;
      DONE:  if (out_ready || flush) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    core_dividend_tvalid = (state == ISSUE) && !dvd_sent;
    core_divisor_tvalid  = (state == ISSUE) && !dvs_sent;
    res_valid            = (state == DONE);
  end

  // Operand latches, per-channel handshake tracking and the held result
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      sel_quot_q <= 1'b0;
      dvd_sent   <= 1'b0;
      dvs_sent   <= 1'b0;
      flush_seen <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      res_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          dvd_sent   <= 1'b0;
          dvs_sent   <= 1'b0;
          flush_seen <= 1'b0;
          if (accept) begin
            s1_q       <= req_s1;
            s2_q       <= req_s2;
            sel_quot_q <= req_is_quot;
            dividend_q <= req_s1 ? (~req_src1 + 1'b1) : req_src1;
            divisor_q  <= req_s2 ? (~req_src2 + 1'b1) : req_src2;
            if (req_zero) res_q <= zero_res;
          end
        end
        ISSUE: begin
          if (dvd_fire) dvd_sent <= 1'b1;
          if (dvs_fire) dvs_sent <= 1'b1;
          if (flush)    flush_seen <= 1'b1;
        end
        WAIT: begin
          if (core_dout_tvalid && !flush) res_q <= res_fix;
        end
        default: ;
      endcase
    end
  end

  assign core_dividend_tdata = dividend_q;
  assign core_divisor_tdata  = divisor_q;
  assign res_data            = res_q;
  assign div_stall           = req_valid & ~res_valid;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl; the bench plays the divider core by hand,
// returning hand-computed unsigned {quotient, remainder} pairs.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        out_ready, flush;
  logic        div_stall, res_valid;
  logic [31:0] res_data;
  logic        core_dividend_tvalid, core_dividend_tready;
  logic [31:0] core_dividend_tdata;
  logic        core_divisor_tvalid, core_divisor_tready;
  logic [31:0] core_divisor_tdata;
  logic        core_dout_tvalid;
  logic [63:0] core_dout_tdata;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] OP_DIV = 4'b0001, OP_MOD = 4'b0010, OP_DIVU = 4'b0100, OP_MODU = 4'b1000;

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .out_ready(out_ready), .flush(flush),
    .div_stall(div_stall), .res_valid(res_valid), .res_data(res_data),
    .core_dividend_tvalid(core_dividend_tvalid), .core_dividend_tready(core_dividend_tready),
    .core_dividend_tdata(core_dividend_tdata),
    .core_divisor_tvalid(core_divisor_tvalid), .core_divisor_tready(core_divisor_tready),
    .core_divisor_tdata(core_divisor_tdata),
    .core_dout_tvalid(core_dout_tvalid), .core_dout_tdata(core_dout_tdata)
  );

  always #5 clk = ~clk;

  // EX must never present a non-one-hot op
  always @(negedge clk) begin
    if (!reset && req_valid) begin
      assert ($onehot(req_op)) else begin
        errors++;
        $error("[TB] FAIL illegal_op: observed=%b expected one-hot", req_op);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full nonzero-divisor op: 1-cycle handshake, 3-cycle core latency, optional hold in DONE
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_dvd, input logic [31:0] exp_dvs,
                        input logic [31:0] core_q, input logic [31:0] core_r,
                        input logic [31:0] exp_res, input int hold);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    tick();
    check_output({tag, "/dvd_tvalid"}, 64'(core_dividend_tvalid), 64'd1);
    check_output({tag, "/dvs_tvalid"}, 64'(core_divisor_tvalid), 64'd1);
    check_output({tag, "/dvd_tdata"}, 64'(core_dividend_tdata), 64'(exp_dvd));
    check_output({tag, "/dvs_tdata"}, 64'(core_divisor_tdata), 64'(exp_dvs));
    check_output({tag, "/stall"}, 64'(div_stall), 64'd1);
    tick();
    check_output({tag, "/tvalid_drop"}, 64'({core_dividend_tvalid, core_divisor_tvalid}), 64'd0);
    tick();
    tick();
    core_dout_tvalid = 1'b1; core_dout_tdata = {core_q, core_r};
    tick();
    core_dout_tvalid = 1'b0; core_dout_tdata = '0;
    check_output({tag, "/res_valid"}, 64'(res_valid), 64'd1);
    check_output({tag, "/res_data"}, 64'(res_data), 64'(exp_res));
    check_output({tag, "/stall_done"}, 64'(div_stall), 64'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_output({tag, "/hold_valid"}, 64'(res_valid), 64'd1);
      check_output({tag, "/hold_data"}, 64'(res_data), 64'(exp_res));
      check_output({tag, "/hold_stall"}, 64'(div_stall), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; req_valid = 1'b0;
    check_output({tag, "/consumed"}, 64'(res_valid), 64'd0);
  endtask

  task automatic run_zero(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] exp_res);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = 32'd0;
    tick();
    check_output({tag, "/res_valid"}, 64'(res_valid), 64'd1);
    check_output({tag, "/res_data"}, 64'(res_data), 64'(exp_res));
    check_output({tag, "/no_core"}, 64'({core_dividend_tvalid, core_divisor_tvalid}), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; req_valid = 1'b0;
    check_output({tag, "/consumed"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = OP_DIV; req_src1 = '0; req_src2 = '0;
    out_ready = 1'b0; flush = 1'b0;
    core_dividend_tready = 1'b1; core_divisor_tready = 1'b1;
    core_dout_tvalid = 1'b0; core_dout_tdata = '0;
    tick();
    tick();
    reset = 1'b0;
    check_output("reset/res_valid", 64'(res_valid), 64'd0);
    check_output("reset/res_data", 64'(res_data), 64'd0);
    check_output("reset/tvalids", 64'({core_dividend_tvalid, core_divisor_tvalid}), 64'd0);

    // Signed and unsigned ops; core is fed magnitudes for signed ops
    run_op("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'h2, 32'd7, 32'd2, 32'd3, 32'd1, 32'hFFFFFFFD, 0);
    run_op("mod_m7_2",   OP_MOD,  32'hFFFFFFF9, 32'h2, 32'd7, 32'd2, 32'd3, 32'd1, 32'hFFFFFFFF, 0);
    run_op("divu_ff_2",  OP_DIVU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 0);
    run_op("modu_ff_2",  OP_MODU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 32'h1, 0);
    run_op("mod_7_m2",   OP_MOD,  32'd7, 32'hFFFFFFFE, 32'd7, 32'd2, 32'd3, 32'd1, 32'h1, 0);
    run_op("div_min_m1", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h80000000, 32'd0, 32'h80000000, 0);

    run_zero("div_5_0", OP_DIV, 32'd5, 32'd0);
    run_zero("mod_5_0", OP_MOD, 32'd5, 32'd5);

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; req_op = OP_DIV; req_src1 = 32'd9; req_src2 = 32'd3; flush = 1'b1;
    tick();
    check_output("idle_flush/no_issue", 64'(core_dividend_tvalid), 64'd0);
    check_output("idle_flush/stall", 64'(div_stall), 64'd1);
    flush = 1'b0; req_valid = 1'b0;

    // Dividend backpressure for 3 cycles, divisor accepted immediately
    core_dividend_tready = 1'b0;
    req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd100; req_src2 = 32'd7;
    tick();
    check_output("bp/c1_dvd", 64'(core_dividend_tvalid), 64'd1);
    check_output("bp/c1_dvs", 64'(core_divisor_tvalid), 64'd1);
    tick();
    check_output("bp/c2_dvs_drop", 64'(core_divisor_tvalid), 64'd0);
    check_output("bp/c2_dvd", 64'(core_dividend_tvalid), 64'd1);
    tick();
    check_output("bp/c3_dvd", 64'(core_dividend_tvalid), 64'd1);
    check_output("bp/c3_data", 64'(core_dividend_tdata), 64'd100);
    tick();
    check_output("bp/c4_dvd", 64'(core_dividend_tvalid), 64'd1);
    check_output("bp/c4_data", 64'(core_dividend_tdata), 64'd100);
    core_dividend_tready = 1'b1;
    tick();
    check_output("bp/wait_dvd", 64'(core_dividend_tvalid), 64'd0);
    tick();
    core_dout_tvalid = 1'b1; core_dout_tdata = {32'd14, 32'd2};
    tick();
    core_dout_tvalid = 1'b0; core_dout_tdata = '0;
    check_output("bp/res_valid", 64'(res_valid), 64'd1);
    check_output("bp/res_data", 64'(res_data), 64'd14);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; req_valid = 1'b0;

    // Flush in WAIT drains the stale core result
    req_valid = 1'b1; req_op = OP_DIV; req_src1 = 32'd20; req_src2 = 32'd3;
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check_output("drain/res_valid", 64'(res_valid), 64'd0);
    tick();
    core_dout_tvalid = 1'b1; core_dout_tdata = {32'd6, 32'd2};
    tick();
    core_dout_tvalid = 1'b0; core_dout_tdata = '0;
    check_output("drain/discard", 64'(res_valid), 64'd0);
    tick();
    check_output("drain/still_idle", 64'(res_valid), 64'd0);

    run_op("div_12_4_hold", OP_DIV, 32'd12, 32'd4, 32'd12, 32'd4, 32'd3, 32'd0, 32'd3, 5);

    // Reset mid-WAIT, then a late core pulse must be ignored
    req_valid = 1'b1; req_op = OP_DIV; req_src1 = 32'd20; req_src2 = 32'd3;
    tick();
    tick();
    tick();
    reset = 1'b1; req_valid = 1'b0;
    tick();
    reset = 1'b0;
    check_output("rst_wait/res_valid", 64'(res_valid), 64'd0);
    check_output("rst_wait/res_data", 64'(res_data), 64'd0);
    check_output("rst_wait/tvalids", 64'({core_dividend_tvalid, core_divisor_tvalid}), 64'd0);
    check_output("rst_wait/stall", 64'(div_stall), 64'd0);
    core_dout_tvalid = 1'b1; core_dout_tdata = {32'd6, 32'd2};
    tick();
    core_dout_tvalid = 1'b0; core_dout_tdata = '0;
    check_output("rst_wait/ignored", 64'(res_valid), 64'd0);
    check_output("rst_wait/data_zero", 64'(res_data), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
